// File: rtl/triad_encode_if.sv
// Bus bundle for triad_encode: request side (hs_valid/hs_index/deadtime)
// plus serial triad output, busy flag and statistics counters.
// The master modport is the request source (board logic or bench); the
// slave modport is the encoder itself.
interface triad_encode_if #(
    parameter int DEAD_W = 4,
    parameter int CNT_W  = 16
);
    logic              hs_valid;
    logic [1:0]        hs_index;
    logic [DEAD_W-1:0] deadtime;
    logic              triad;
    logic              busy;
    logic [CNT_W-1:0]  sent_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        output hs_valid,
        output hs_index,
        output deadtime,
        input  triad,
        input  busy,
        input  sent_cnt,
        input  drop_cnt
    );

    modport slave (
        input  hs_valid,
        input  hs_index,
        input  deadtime,
        output triad,
        output busy,
        output sent_cnt,
        output drop_cnt
    );
endinterface

// File: rtl/triad_encode.sv
// triad_encode: serial triad transmitter (comparator emulator for one distrip).
// Sends start(1), strip bit, half-strip bit, then holds the line low for
// 'deadtime' clocks plus one IDLE clock so the decoder always sees a zero
// between triads.
// Optional feature: define TRIAD_ENCODE_QUEUE_EN to add a 1-deep pending
// register so one request arriving while busy is held instead of dropped.
module triad_encode #(
    parameter int DEAD_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic          clock,
    input  logic          reset,
    triad_encode_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_STRIP  = 3'd2,
        S_HSTRIP = 3'd3,
        S_DEAD   = 3'd4
    } state_t;

    localparam logic [DEAD_W-1:0] DEAD_ZERO = {DEAD_W{1'b0}};
    localparam logic [DEAD_W-1:0] DEAD_ONE  = {{(DEAD_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    state_t            state_q;
    logic [1:0]        idx_q;
    logic [DEAD_W-1:0] dead_q;
    logic              triad_q;
    logic              busy_q;
    logic [CNT_W-1:0]  sent_q;
    logic [CNT_W-1:0]  drop_q;
    logic [CNT_W-1:0]  sent_d;
    logic [CNT_W-1:0]  drop_d;
    logic              drop_s;
    logic              sent_inc_s;
    logic              idle_busy_s;

`ifdef TRIAD_ENCODE_QUEUE_EN
    logic              pend_v_q;
    logic [1:0]        pend_idx_q;
    logic              pend_v_d;
    logic [1:0]        pend_idx_d;

    // Pending-slot bookkeeping: refill on issue from IDLE, capture while busy, else drop.
    always_comb begin
        pend_v_d   = pend_v_q;
        pend_idx_d = pend_idx_q;
        drop_s     = 1'b0;
        if (state_q == S_IDLE) begin
            if (pend_v_q) begin
                // Pending entry is issued this clock; a new request takes its place.
                pend_v_d = bus.hs_valid;
                if (bus.hs_valid) begin
                    pend_idx_d = bus.hs_index;
                end else begin
                    pend_idx_d = pend_idx_q;
                end
            end else begin
                pend_v_d = 1'b0;
            end
        end else if (bus.hs_valid) begin
            if (!pend_v_q) begin
                pend_v_d   = 1'b1;
                pend_idx_d = bus.hs_index;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            drop_s = 1'b0;
        end
    end

    // Busy must stay high on return to IDLE when a request is still waiting.
    assign idle_busy_s = pend_v_d;
`else
    // Without the pending slot any request seen outside IDLE is lost.
    always_comb begin
        drop_s = 1'b0;
        if ((state_q != S_IDLE) && bus.hs_valid) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    assign idle_busy_s = 1'b0;
`endif

    // Statistics next-state: sent counts HSTRIP exits, drop counts refused requests.
    always_comb begin
        sent_inc_s = (state_q == S_HSTRIP);
        sent_d     = sent_q;
        drop_d     = drop_q;
        if (sent_inc_s) begin
            sent_d = sat_inc(sent_q);
        end else begin
            sent_d = sent_q;
        end
        if (drop_s) begin
            drop_d = sat_inc(drop_q);
        end else begin
            drop_d = drop_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sent_q <= {CNT_W{1'b0}};
            drop_q <= {CNT_W{1'b0}};
        end else begin
            sent_q <= sent_d;
            drop_q <= drop_d;
        end
    end

    // Triad FSM: triad and busy are registered alongside the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'b00;
            dead_q     <= DEAD_ZERO;
            triad_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef TRIAD_ENCODE_QUEUE_EN
            pend_v_q   <= 1'b0;
            pend_idx_q <= 2'b00;
`endif
        end else begin
`ifdef TRIAD_ENCODE_QUEUE_EN
            pend_v_q   <= pend_v_d;
            pend_idx_q <= pend_idx_d;
`endif
            case (state_q)
                S_IDLE: begin
`ifdef TRIAD_ENCODE_QUEUE_EN
                    if (pend_v_q) begin
                        state_q <= S_START;
                        idx_q   <= pend_idx_q;
                        triad_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (bus.hs_valid) begin
`else
                    if (bus.hs_valid) begin
`endif
                        state_q <= S_START;
                        idx_q   <= bus.hs_index;
                        triad_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        triad_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                S_START: begin
                    state_q <= S_STRIP;
                    triad_q <= idx_q[1];
                    busy_q  <= 1'b1;
                end
                S_STRIP: begin
                    state_q <= S_HSTRIP;
                    triad_q <= idx_q[0];
                    busy_q  <= 1'b1;
                end
                S_HSTRIP: begin
                    // deadtime is only looked at here, so later changes
                    // cannot stretch or cut the current dead period.
                    dead_q  <= bus.deadtime;
                    triad_q <= 1'b0;
                    if (bus.deadtime == DEAD_ZERO) begin
                        state_q <= S_IDLE;
                        busy_q  <= idle_busy_s;
                    end else begin
                        state_q <= S_DEAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_DEAD: begin
                    triad_q <= 1'b0;
                    if (dead_q == DEAD_ONE) begin
                        state_q <= S_IDLE;
                        dead_q  <= DEAD_ZERO;
                        busy_q  <= idle_busy_s;
                    end else begin
                        state_q <= S_DEAD;
                        dead_q  <= dead_q - DEAD_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    dead_q  <= DEAD_ZERO;
                    triad_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.triad    = triad_q;
    assign bus.busy     = busy_q;
    assign bus.sent_cnt = sent_q;
    assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_triad_encode.sv
// Directed bench for triad_encode. Expected triad bits are pushed to a
// scoreboard queue as each request is driven and popped one per clock.
// A second instance with 2-bit counters exercises saturation.
module tb_triad_encode;

    logic clock = 1'b0;
    logic rst;
    logic sat_rst;

    always #5 clock = ~clock;

    triad_encode_if #(.DEAD_W(4), .CNT_W(16)) bus ();
    triad_encode_if #(.DEAD_W(4), .CNT_W(2))  sat_bus ();

    triad_encode #(.DEAD_W(4), .CNT_W(16)) u_dut (
        .clock (clock),
        .reset (rst),
        .bus   (bus.slave)
    );

    triad_encode #(.DEAD_W(4), .CNT_W(2)) u_sat (
        .clock (clock),
        .reset (sat_rst),
        .bus   (sat_bus.slave)
    );

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push3(input logic [1:0] ix);
        exp_q.push_back(1'b1);
        exp_q.push_back(ix[1]);
        exp_q.push_back(ix[0]);
    endtask

    task automatic push_zeros(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(1'b0);
    endtask

    // One clock; sample 1 time unit after the edge and compare the next expected bit.
    task automatic tick();
        logic e;
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("triad", {31'd0, bus.triad}, {31'd0, e});
        end
    endtask

    initial begin
        logic [1:0] ix;
        rst              = 1'b1;
        sat_rst          = 1'b1;
        bus.hs_valid     = 1'b0;
        bus.hs_index     = 2'b00;
        bus.deadtime     = 4'd0;
        sat_bus.hs_valid = 1'b0;
        sat_bus.hs_index = 2'b00;
        sat_bus.deadtime = 4'd0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state
        check("rst_triad", {31'd0, bus.triad}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy},  32'd0);
        check("rst_sent",  {16'd0, bus.sent_cnt}, 32'd0);
        check("rst_drop",  {16'd0, bus.drop_cnt}, 32'd0);
        rst     = 1'b0;
        sat_rst = 1'b0;

        // 1: idx 2'b10, deadtime 0 -> 1,1,0 then idle
        bus.deadtime = 4'd0;
        bus.hs_valid = 1'b1;
        bus.hs_index = 2'b10;
        push3(2'b10);
        push_zeros(1);
        tick();
        check("t1_busy1", {31'd0, bus.busy}, 32'd1);
        bus.hs_valid = 1'b0;
        bus.hs_index = 2'b11;
        tick();
        check("t1_busy2", {31'd0, bus.busy}, 32'd1);
        tick();
        check("t1_busy3", {31'd0, bus.busy}, 32'd1);
        tick();
        check("t1_busy_end", {31'd0, bus.busy}, 32'd0);
        check("t1_sent", {16'd0, bus.sent_cnt}, 32'd1);

        // 2: index sweep, deadtime 2 -> start bits 6 clocks apart
        bus.deadtime = 4'd2;
        for (int i = 0; i < 4; i++) begin
            ix = i[1:0];
            bus.hs_valid = 1'b1;
            bus.hs_index = ix;
            push3(ix);
            push_zeros(3);
            tick();
            bus.hs_valid = 1'b0;
            repeat (5) tick();
        end
        check("t2_sent", {16'd0, bus.sent_cnt}, 32'd5);
        check("t2_drop", {16'd0, bus.drop_cnt}, 32'd0);

`ifndef TRIAD_ENCODE_QUEUE_EN
        // 3: hs_valid held 8 clocks, deadtime 3 -> 6 drops, re-accept in IDLE clock
        bus.deadtime = 4'd3;
        bus.hs_valid = 1'b1;
        bus.hs_index = 2'b01;
        push3(2'b01);
        push_zeros(4);
        exp_q.push_back(1'b1);
        repeat (8) tick();
        bus.hs_valid = 1'b0;
        check("t3_drop", {16'd0, bus.drop_cnt}, 32'd6);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        tick();
        tick();
        tick();
        // deadtime already sampled at HSTRIP exit; this change must not shorten DEAD
        bus.deadtime = 4'd0;
        push_zeros(3);
        tick();
        tick();
        check("t3_busy_dead", {31'd0, bus.busy}, 32'd1);
        tick();
        check("t3_busy_end", {31'd0, bus.busy}, 32'd0);
        check("t3_sent", {16'd0, bus.sent_cnt}, 32'd7);
`else
        // 4: queued back-to-back requests, deadtime 1
        bus.deadtime = 4'd1;
        bus.hs_valid = 1'b1;
        bus.hs_index = 2'b01;
        push3(2'b01);
        push_zeros(2);
        push3(2'b11);
        push_zeros(2);
        tick();
        bus.hs_index = 2'b11;
        tick();
        bus.hs_valid = 1'b0;
        repeat (8) tick();
        check("t4_drop", {16'd0, bus.drop_cnt}, 32'd0);
        check("t4_sent", {16'd0, bus.sent_cnt}, 32'd7);
        check("t4_busy_end", {31'd0, bus.busy}, 32'd0);
`endif

        // 5: reset pulsed during STRIP of an idx3 triad
        bus.deadtime = 4'd0;
        bus.hs_valid = 1'b1;
        bus.hs_index = 2'b11;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        tick();
        bus.hs_valid = 1'b0;
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_triad", {31'd0, bus.triad}, 32'd0);
        check("t5_async_busy",  {31'd0, bus.busy},  32'd0);
        check("t5_async_sent",  {16'd0, bus.sent_cnt}, 32'd0);
        #2;
        rst = 1'b0;
        bus.hs_valid = 1'b1;
        bus.hs_index = 2'b11;
        push3(2'b11);
        push_zeros(1);
        tick();
        bus.hs_valid = 1'b0;
        repeat (3) tick();
        check("t5_sent", {16'd0, bus.sent_cnt}, 32'd1);
        check("t5_busy", {31'd0, bus.busy}, 32'd0);

`ifndef TRIAD_ENCODE_QUEUE_EN
        // 6: saturation on the 2-bit-counter instance; request held high, deadtime 0
        sat_bus.deadtime = 4'd0;
        sat_bus.hs_index = 2'b10;
        sat_bus.hs_valid = 1'b1;
        repeat (4) tick();
        check("t6_sent_a", {30'd0, sat_bus.sent_cnt}, 32'd1);
        check("t6_drop_a", {30'd0, sat_bus.drop_cnt}, 32'd3);
        repeat (4) tick();
        check("t6_sent_b", {30'd0, sat_bus.sent_cnt}, 32'd2);
        check("t6_drop_b", {30'd0, sat_bus.drop_cnt}, 32'd3);
        repeat (12) tick();
        sat_bus.hs_valid = 1'b0;
        check("t6_sent_c", {30'd0, sat_bus.sent_cnt}, 32'd3);
        check("t6_drop_c", {30'd0, sat_bus.drop_cnt}, 32'd3);
`endif

        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
